mem_line_arb: RTL and testbench

MEM_LINE_ARB -- requirements
Module: mem_line_arb

---
 rtl/mem_line_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/mem_line_arb.sv | 152 +++++++++++++++
 tb/tb_mem_line_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_arb_pkg.sv
// Shared types and sizing for the two-client line arbiter: FSM encoding, line geometry, word select.
package mem_line_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int WORD_OFF_W = 2;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                    input logic [WORD_OFF_W-1:0] k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (k == WORD_OFF_W'(i)) w = line[i*WORD_W +: WORD_W];
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, a tie goes to the client not served last.
// The last-served flop only moves on i_upd_vld and powers up pointing at requester 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd_vld,
    input  logic       i_upd_id,
    output logic       o_gnt_vld,
    output logic       o_gnt_id
);

    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_upd_vld) begin
            r_last <= i_upd_id;
        end
    end

    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_id  = 1'b0;
        if (&i_req) begin
            o_gnt_id = ~r_last;
        end else begin
            o_gnt_id = i_req[1];
        end
    end

endmodule

// File: rtl/mem_line_arb.sv
// Two-client cache-line engine: optional 4-word victim write-back, then a 4-word fill, one op in flight.
// Unstalled fill-only is 6 cycles grant-to-done; mem_stall freezes the current access until accepted.
module mem_line_arb
    import mem_line_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c1_req,
    input  logic              c0_wb,
    input  logic              c1_wb,
    input  logic [ADDR_W-1:0] c0_fill_addr,
    input  logic [ADDR_W-1:0] c1_fill_addr,
    input  logic [ADDR_W-1:0] c0_wb_addr,
    input  logic [ADDR_W-1:0] c1_wb_addr,
    input  logic [LINE_W-1:0] c0_wb_data,
    input  logic [LINE_W-1:0] c1_wb_data,
    output logic              c0_done,
    output logic              c1_done,
    output logic [LINE_W-1:0] c0_rdata,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              c0_err,
    output logic              c1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_err
);

    localparam int LINE_OFF = WORD_OFF_W + 2;
    localparam int LA_W     = ADDR_W - LINE_OFF;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_OFF_W-1:0] r_k;
    logic                  r_id;
    logic [LA_W-1:0]       r_fill_line;
    logic [LA_W-1:0]       r_wb_line;
    logic [LINE_W-1:0]     r_wb_data;
    logic [LINE_W-1:0]     r_line;
    logic                  r_err;

    logic                  w_gnt_vld;
    logic                  w_gnt_id;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_done;
    logic                  w_sel_wb;
    logic [ADDR_W-1:0]     w_sel_fill_addr;
    logic [ADDR_W-1:0]     w_sel_wb_addr;
    logic [LINE_W-1:0]     w_sel_wb_data;
    logic                  w_unused_addr_bits;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({c1_req, c0_req}),
        .i_upd_vld (w_done),
        .i_upd_id  (r_id),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    assign w_sel_wb        = w_gnt_id ? c1_wb        : c0_wb;
    assign w_sel_fill_addr = w_gnt_id ? c1_fill_addr : c0_fill_addr;
    assign w_sel_wb_addr   = w_gnt_id ? c1_wb_addr   : c0_wb_addr;
    assign w_sel_wb_data   = w_gnt_id ? c1_wb_data   : c0_wb_data;

    // Byte-within-line bits are replaced by the word counter on the memory side.
    assign w_unused_addr_bits = ^{c0_fill_addr[LINE_OFF-1:0], c1_fill_addr[LINE_OFF-1:0],
                                  c0_wb_addr[LINE_OFF-1:0],   c1_wb_addr[LINE_OFF-1:0]};

    assign w_grant     = (r_state == ST_IDLE) && w_gnt_vld;
    assign w_accept    = ((r_state == ST_WB) || (r_state == ST_FILL)) && !mem_stall;
    assign w_last_word = (r_k == WORD_OFF_W'(LINE_WORDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) w_state_nxt = w_sel_wb ? ST_WB : ST_FILL;
            end
            ST_WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {r_wb_line, r_k, 2'b00};
                mem_wdata = line_word(r_wb_data, r_k);
                if (w_accept && w_last_word) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {r_fill_line, r_k, 2'b00};
                if (w_accept && w_last_word) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_k wraps 3->0 on the last write-back word, so the fill phase starts at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_id        <= 1'b0;
            r_fill_line <= '0;
            r_wb_line   <= '0;
            r_wb_data   <= '0;
            r_line      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_id        <= w_gnt_id;
                r_fill_line <= w_sel_fill_addr[ADDR_W-1:LINE_OFF];
                r_wb_line   <= w_sel_wb_addr[ADDR_W-1:LINE_OFF];
                r_wb_data   <= w_sel_wb_data;
                r_k         <= '0;
                r_err       <= 1'b0;
            end else if (w_accept) begin
                r_k   <= r_k + WORD_OFF_W'(1);
                r_err <= r_err | mem_err;
                if (r_state == ST_FILL) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (r_k == WORD_OFF_W'(i)) r_line[i*WORD_W +: WORD_W] <= mem_rdata;
                    end
                end
            end
        end
    end

    assign c0_done  = w_done & ~r_id;
    assign c1_done  = w_done &  r_id;
    assign c0_err   = c0_done & r_err;
    assign c1_err   = c1_done & r_err;
    assign c0_rdata = r_line;
    assign c1_rdata = r_line;

endmodule

// File: tb/tb_mem_line_arb.sv
// Self-checking bench: transaction-queue model of grants/accesses/completions plus directed literal cases.
module tb_mem_line_arb;
    import mem_line_arb_pkg::*;

    localparam int ADDR_W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         c0_req, c1_req, c0_wb, c1_wb;
    logic [31:0]  c0_fill_addr, c1_fill_addr, c0_wb_addr, c1_wb_addr;
    logic [127:0] c0_wb_data, c1_wb_data;
    logic         c0_done, c1_done, c0_err, c1_err;
    logic [127:0] c0_rdata, c1_rdata;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         mem_rd, mem_wr, mem_stall, mem_err;

    always #5 clk = ~clk;

    mem_line_arb #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c1_req(c1_req), .c0_wb(c0_wb), .c1_wb(c1_wb),
        .c0_fill_addr(c0_fill_addr), .c1_fill_addr(c1_fill_addr),
        .c0_wb_addr(c0_wb_addr), .c1_wb_addr(c1_wb_addr),
        .c0_wb_data(c0_wb_data), .c1_wb_data(c1_wb_data),
        .c0_done(c0_done), .c1_done(c1_done), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .c0_err(c0_err), .c1_err(c1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Word memory behind the DUT, indexed by address bits [9:2].
    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        int          k;
    } acc_t;

    acc_t         exp_q[$];
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    bit           m_id;
    logic [127:0] m_line;
    bit           m_err;
    int           acc_idx;

    int stall_pct = 0, err_pct = 0, stall_at = -1, stall_left = 0, err_at = -1;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit done_seen[2];
    int done_cnt[2];
    int done_cyc[2];
    logic [127:0] done_rdata[2];
    logic done_err[2];
    int done_order[$];
    int cnt_rd108 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_grant(input bit id);
        logic [31:0]  fa, wa;
        logic [127:0] wd;
        bit           wb;
        fa = id ? c1_fill_addr : c0_fill_addr;
        wa = id ? c1_wb_addr   : c0_wb_addr;
        wd = id ? c1_wb_data   : c0_wb_data;
        wb = id ? c1_wb        : c0_wb;
        m_id = id; m_busy = 1'b1; m_err = 1'b0; acc_idx = 0;
        exp_q.delete();
        if (wb) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{addr: (wa & 32'hFFFF_FFF0) + 32'(k * 4), wr: 1'b1,
                                  wdata: wd[k*32 +: 32], k: k});
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{addr: (fa & 32'hFFFF_FFF0) + 32'(k * 4), wr: 1'b0,
                              wdata: 32'h0, k: k});
    endtask

    // Memory-side driver and cycle-by-cycle comparison against the transaction model.
    always @(negedge clk) begin
        bit   st, er;
        acc_t h;
        st = 1'b0; er = 1'b0;
        if (m_busy && exp_q.size() > 0) begin
            if (stall_at == acc_idx && stall_left > 0) begin
                st = 1'b1; stall_left--;
            end else if (stall_at < 0) begin
                st = ($urandom_range(0, 99) < stall_pct);
            end
            if (err_at == acc_idx) er = 1'b1;
            else if (err_at < 0) er = ($urandom_range(0, 99) < err_pct);
        end else begin
            st = 1'($urandom_range(0, 1));
            er = 1'($urandom_range(0, 1));
        end
        mem_stall = st;
        mem_err   = er;
        mem_rdata = mem[mem_addr[9:2]];

        if (mon_en) begin
            check("rd_wr_exclusive", {mem_rd, mem_wr} == 2'b11, 1'b0);
            if (c0_done) begin
                done_seen[0] = 1'b1; done_cnt[0]++; done_cyc[0] = cyc;
                done_rdata[0] = c0_rdata; done_err[0] = c0_err; done_order.push_back(0);
            end
            if (c1_done) begin
                done_seen[1] = 1'b1; done_cnt[1]++; done_cyc[1] = cyc;
                done_rdata[1] = c1_rdata; done_err[1] = c1_err; done_order.push_back(1);
            end
            if (mem_rd && mem_addr == 32'h108) cnt_rd108++;

            if (!m_busy) begin
                check("idle_quiet", {mem_rd, mem_wr, c0_done, c1_done}, 4'b0);
            end else if (exp_q.size() > 0) begin
                h = exp_q[0];
                check("acc_wr", mem_wr, h.wr);
                check("acc_rd", mem_rd, !h.wr);
                check("acc_addr", mem_addr, h.addr);
                if (h.wr) check("acc_wdata", mem_wdata, h.wdata);
                check("no_early_done", {c0_done, c1_done}, 2'b0);
            end else begin
                check("done_c0", c0_done, m_id == 1'b0);
                check("done_c1", c1_done, m_id == 1'b1);
                check("done_rdata", m_id ? c1_rdata : c0_rdata, m_line);
                check("done_err", m_id ? c1_err : c0_err, m_err);
                check("done_quiet", {mem_rd, mem_wr}, 2'b0);
            end

            if (rst) begin
                m_busy = 1'b0; m_last = 1'b1; exp_q.delete();
            end else if (!m_busy) begin
                if (c0_req || c1_req) model_grant((c0_req && c1_req) ? !m_last : c1_req);
            end else if (exp_q.size() > 0) begin
                if (!mem_stall) begin
                    h = exp_q.pop_front();
                    if (h.wr) mem[mem_addr[9:2]] = mem_wdata;
                    else m_line[h.k*32 +: 32] = mem_rdata;
                    m_err = m_err | mem_err;
                    acc_idx++;
                end
            end else begin
                m_last = m_id;
                m_busy = 1'b0;
            end
        end
    end

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input int c, input logic req, input logic wb, input logic [31:0] fa,
                         input logic [31:0] wa, input logic [127:0] wd);
        if (c == 0) begin
            c0_req = req; c0_wb = wb; c0_fill_addr = fa; c0_wb_addr = wa; c0_wb_data = wd;
        end else begin
            c1_req = req; c1_wb = wb; c1_fill_addr = fa; c1_wb_addr = wa; c1_wb_data = wd;
        end
    endtask

    // Called just after a rising edge; returns request-to-done latency in cycles, inclusive.
    task automatic client_op(input int c, input logic wb, input logic [31:0] fa, input logic [31:0] wa,
                             input logic [127:0] wd, input bit scramble, output int lat);
        int t0;
        bit got;
        drive(c, 1'b1, wb, fa, wa, wd);
        done_seen[c] = 1'b0;
        t0 = cyc; got = 1'b0; lat = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            if (done_seen[c]) got = 1'b1;
            else if (scramble) drive(c, 1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(), rand_line());
        end
        if (c == 0) c0_req = 1'b0; else c1_req = 1'b0;
        check($sformatf("c%0d_done_within_bound", c), got, 1'b1);
        if (got) lat = done_cyc[c] - t0 + 1;
    endtask

    task automatic client_loop(input int c, input int n);
        int g, lat;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            client_op(c, 1'($urandom_range(0, 1)), $urandom(), $urandom(), rand_line(), 1'b1, lat);
        end
    endtask

    task automatic preset_a_line();
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'hA0 + 32'(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, dc;
        int exp_ord[4] = '{0, 1, 0, 1};
        logic [127:0] wd;

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_rd", mem_rd, 1'b0);
        check("reset_mem_wr", mem_wr, 1'b0);
        check("reset_done", {c0_done, c1_done}, 2'b0);
        check("reset_err", {c0_err, c1_err}, 2'b0);
        check("reset_rdata", c0_rdata, 128'h0);
        @(posedge clk); #1;

        // Plain fill for client 0.
        preset_a_line();
        client_op(0, 1'b0, 32'h100, 32'h0, 128'h0, 1'b0, lat);
        check("fill_latency", lat, 6);
        check("fill_rdata", done_rdata[0], 128'h000000A3_000000A2_000000A1_000000A0);
        check("fill_err", done_err[0], 1'b0);

        // Write-back then fill for client 1.
        for (int i = 0; i < 4; i++) mem[8'hC0 + i] = 32'hB0 + 32'(i);
        wd = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
        dc = done_cnt[1];
        client_op(1, 1'b1, 32'h300, 32'h200, wd, 1'b0, lat);
        check("wb_latency", lat, 10);
        for (int i = 0; i < 4; i++)
            check($sformatf("wb_word%0d", i), mem[8'h80 + i], 32'hDDDD0000 + 32'(i));
        check("wb_fill_rdata", done_rdata[1], 128'h000000B3_000000B2_000000B1_000000B0);
        check("wb_single_done", done_cnt[1] - dc, 1);

        // Simultaneous requests alternate.
        done_order.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                begin int l0; client_op(0, 1'b0, 32'h400, 32'h0, 128'h0, 1'b0, l0); end
                begin int l1; client_op(1, 1'b0, 32'h500, 32'h0, 128'h0, 1'b0, l1); end
            join
        end
        check("rr_count", done_order.size(), 4);
        for (int i = 0; i < 4 && i < done_order.size(); i++)
            check($sformatf("rr_order%0d", i), done_order[i], exp_ord[i]);

        // Three stall cycles on fill word 2.
        preset_a_line();
        cnt_rd108 = 0; stall_at = 2; stall_left = 3;
        client_op(0, 1'b0, 32'h100, 32'h0, 128'h0, 1'b0, lat);
        stall_at = -1;
        check("stall_latency", lat, 9);
        check("stall_hold_cycles", cnt_rd108, 4);
        check("stall_rdata", done_rdata[0], 128'h000000A3_000000A2_000000A1_000000A0);

        // Error on one fill word, then a clean op.
        err_at = 1;
        client_op(0, 1'b0, 32'h100, 32'h0, 128'h0, 1'b0, lat);
        err_at = -1;
        check("err_reported", done_err[0], 1'b1);
        client_op(1, 1'b0, 32'h300, 32'h0, 128'h0, 1'b0, lat);
        check("err_cleared", done_err[1], 1'b0);

        // Reset in the middle of a write-back.
        dc = done_cnt[1];
        drive(1, 1'b1, 1'b1, 32'h300, 32'h200, wd);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; c1_req = 1'b0;
        @(negedge clk);
        check("midwb_writing", mem_wr, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_wr", mem_wr, 1'b0);
        check("post_rst_rdata", c1_rdata, 128'h0);
        repeat (8) @(posedge clk);
        #1;
        check("abandoned_no_done", done_cnt[1] - dc, 0);
        preset_a_line();
        client_op(1, 1'b0, 32'h100, 32'h0, 128'h0, 1'b0, lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_rdata_fill", done_rdata[1], 128'h000000A3_000000A2_000000A1_000000A0);

        // Randomised traffic from both clients.
        stall_pct = 30; err_pct = 10;
        fork
            client_loop(0, 15);
            client_loop(1, 15);
        join
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
